// File: rtl/br_svc_rx_queue.sv
// br_svc_rx_queue: receive-side buffer between the BrLite router local output
// and the DMNI NI stage. Filters service flits by address and class, queues
// accepted entries, presents the head to the NI and counts discarded flits.
//
// Handshake semantics (router side): br_req_i is a level held by the router
// until it sees the one-cycle br_ack_o pulse. A request is evaluated only in
// cycles where br_ack_o is low, so a sender that is slow to drop br_req_i is
// never double-counted. NI side: svc_rx_o high means svc_data_o holds a valid
// head entry; a svc_ack_i pulse while svc_rx_o is high pops that entry, a
// pulse while empty is ignored.

package br_svc_rx_queue_pkg;

  typedef enum logic [1:0] {
    BR_SVC_ALL       = 2'b00,
    BR_SVC_TGT       = 2'b01,
    BR_SVC_MON_CLEAR = 2'b10,
    BR_SVC_MON       = 2'b11
  } br_svc_e;

  typedef struct packed {
    logic [1:0]  service;
    logic [7:0]  ksvc;
    logic [15:0] seq_target;   // {seq[15:8], target[7:0]}
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_out_t;

  typedef struct packed {
    logic [7:0]  ksvc;
    logic [15:0] seq_source;   // {seq[15:8], source[7:0]}
    logic [15:0] producer;
    logic [31:0] payload;
  } brlite_svc_t;

endpackage

module br_svc_rx_queue
  import br_svc_rx_queue_pkg::*;
#(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] ADDRESS = 16'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     br_req_i,
  output logic                     br_ack_o,
  input  brlite_out_t              br_data_i,
  output logic                     svc_rx_o,
  input  logic                     svc_ack_i,
  output brlite_svc_t              svc_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drop_cnt_o,
  input  logic                     drop_clr_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Registered state
  logic              r_ack;
  logic              r_push_pend;   // accepted flit waiting to be written
  brlite_svc_t       r_wr_data;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_rx;
  logic [15:0]       r_drop_cnt;
  brlite_svc_t       r_mem [DEPTH];

  // Combinational decode
  logic              w_eval;
  logic              w_target_hit;
  logic              w_accept;
  logic              w_full;
  logic              w_take;
  logic              w_discard;
  logic              w_write;
  logic              w_pop;
  logic [CW-1:0]     w_count_nxt;
  brlite_svc_t       w_entry;

  // Filter decision; full comes from registered state only, so svc_ack_i never
  // reaches br_ack_o combinationally.
  always_comb begin
    w_eval       = br_req_i & ~r_ack;
    w_target_hit = (br_data_i.seq_target[7:0] == ADDRESS[7:0]);
    w_accept     = (br_data_i.service == BR_SVC_ALL) |
                   ((br_data_i.service == BR_SVC_TGT) & w_target_hit);
    w_full       = (r_count == CW'(DEPTH));
    w_take       = w_eval & w_accept & ~w_full;
    w_discard    = w_eval & ~w_accept;
    w_write      = r_push_pend;
    w_pop        = svc_ack_i & r_rx;
    w_count_nxt  = r_count + CW'(w_write) - CW'(w_pop);
  end

  // Entry layout: source byte is taken from the producer's low byte.
  always_comb begin
    w_entry            = '0;
    w_entry.ksvc       = br_data_i.ksvc;
    w_entry.seq_source = {br_data_i.seq_target[15:8], br_data_i.producer[7:0]};
    w_entry.producer   = br_data_i.producer;
    w_entry.payload    = br_data_i.payload;
  end

  // Router handshake: one-cycle ack, accepted flit staged for the next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ack       <= 1'b0;
      r_push_pend <= 1'b0;
      r_wr_data   <= '0;
    end else begin
      r_ack       <= w_take | w_discard;
      r_push_pend <= w_take;
      if (w_take) begin
        r_wr_data <= w_entry;
      end
    end
  end

  // Pointers, occupancy and the registered non-empty flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rx     <= 1'b0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= w_count_nxt;
      r_rx    <= (w_count_nxt != '0);
    end
  end

  // Storage array; contents are meaningless while the queue is empty.
  always_ff @(posedge clk_i) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= r_wr_data;
    end
  end

  // Saturating discard counter; clear wins over a same-cycle increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drop_cnt <= '0;
    end else if (drop_clr_i) begin
      r_drop_cnt <= '0;
    end else if (w_discard && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Outputs; head data is forced to zero while empty so stale entries never show.
  always_comb begin
    br_ack_o   = r_ack;
    svc_rx_o   = r_rx;
    count_o    = r_count;
    drop_cnt_o = r_drop_cnt;
    svc_data_o = r_rx ? r_mem[r_rd_ptr] : '0;
  end

endmodule

// File: tb/tb_br_svc_rx_queue.sv
// Bench for br_svc_rx_queue: table of filter vectors plus hand-written
// sequences for full/backpressure, wrap-around, empty pops and async reset.
module tb_br_svc_rx_queue;
  import br_svc_rx_queue_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [15:0] ADDR  = 16'h0123;
  localparam int          SVC_W = $bits(brlite_svc_t);
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic              clk_i;
  logic              rst_ni;
  logic              br_req_i;
  logic              br_ack_o;
  brlite_out_t       br_data_i;
  logic              svc_rx_o;
  logic              svc_ack_i;
  brlite_svc_t       svc_data_o;
  logic [CW-1:0]     count_o;
  logic [15:0]       drop_cnt_o;
  logic              drop_clr_i;

  int n_tests = 0;
  int n_fail  = 0;
  logic [SVC_W-1:0] exp_q[$];
  brlite_out_t cur_flit;

  typedef struct {
    logic [1:0]  svc;
    logic [7:0]  target;
    logic [31:0] payload;
    bit          accept;
    logic [15:0] exp_drop;
    logic [CW-1:0] exp_count;
  } vec_t;
  vec_t vecs[6];

  br_svc_rx_queue #(.DEPTH(DEPTH), .ADDRESS(ADDR)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .br_req_i   (br_req_i),
    .br_ack_o   (br_ack_o),
    .br_data_i  (br_data_i),
    .svc_rx_o   (svc_rx_o),
    .svc_ack_i  (svc_ack_i),
    .svc_data_o (svc_data_o),
    .count_o    (count_o),
    .drop_cnt_o (drop_cnt_o),
    .drop_clr_i (drop_clr_i)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic brlite_out_t mk_flit(input logic [1:0] svc, input logic [7:0] target,
                                          input logic [31:0] payload);
    brlite_out_t f;
    f.service    = svc;
    f.ksvc       = 8'($urandom_range(0, 255));
    f.seq_target = {8'($urandom_range(0, 255)), target};
    f.producer   = 16'($urandom_range(0, 65535));
    f.payload    = payload;
    return f;
  endfunction

  // Expected queue entry for a flit: seq byte and producer low byte form seq_source.
  function automatic logic [SVC_W-1:0] model_entry(input brlite_out_t f);
    brlite_svc_t e;
    e.ksvc       = f.ksvc;
    e.seq_source = {f.seq_target[15:8], f.producer[7:0]};
    e.producer   = f.producer;
    e.payload    = f.payload;
    return e;
  endfunction

  // Driver tasks
  task automatic drive_flit(input logic [1:0] svc, input logic [7:0] target,
                            input logic [31:0] payload);
    cur_flit  = mk_flit(svc, target, payload);
    br_data_i = cur_flit;
    br_req_i  = 1'b1;
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!br_ack_o && lat < 20);
    if (!br_ack_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_timeout: got no ack after %0d cycles expected ack", lat);
    end
  endtask

  // Full router transaction: request, ack after one cycle, pulse ends next cycle.
  task automatic send(input logic [1:0] svc, input logic [7:0] target,
                      input logic [31:0] payload, input bit accept);
    int lat;
    drive_flit(svc, target, payload);
    wait_ack(lat);
    check("ack_latency", 128'(lat), 128'd1);
    if (accept) exp_q.push_back(model_entry(cur_flit));
    br_req_i = 1'b0;
    tick();
    check("ack_one_cycle", 128'(br_ack_o), 128'd0);
  endtask

  // Scoreboard pop: compare head against expected queue, then pulse svc_ack_i.
  task automatic pop_check();
    logic [SVC_W-1:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pop_unexpected: got entry %0h expected empty queue", svc_data_o);
    end else begin
      e = exp_q.pop_front();
      check("pop_data", 128'(svc_data_o), 128'(e));
    end
    svc_ack_i = 1'b1;
    tick();
    svc_ack_i = 1'b0;
  endtask

  initial begin
    int lat;
    int acks;
    int iter;

    vecs[0] = '{BR_SVC_TGT,       ADDR[7:0] + 8'd1, 32'h100, 1'b0, 16'd1, 4'd0};
    vecs[1] = '{BR_SVC_MON,       ADDR[7:0],        32'h101, 1'b0, 16'd2, 4'd0};
    vecs[2] = '{BR_SVC_ALL,       8'h55,            32'h102, 1'b1, 16'd2, 4'd1};
    vecs[3] = '{BR_SVC_TGT,       ADDR[7:0],        32'h103, 1'b1, 16'd2, 4'd2};
    vecs[4] = '{BR_SVC_MON_CLEAR, ADDR[7:0],        32'h104, 1'b0, 16'd3, 4'd2};
    vecs[5] = '{BR_SVC_TGT,       8'h00,            32'h105, 1'b0, 16'd4, 4'd2};

    // Reset
    rst_ni     = 1'b0;
    br_req_i   = 1'b0;
    br_data_i  = '0;
    svc_ack_i  = 1'b0;
    drop_clr_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ack",   128'(br_ack_o),   128'd0);
    check("rst_rx",    128'(svc_rx_o),   128'd0);
    check("rst_count", 128'(count_o),    128'd0);
    check("rst_drop",  128'(drop_cnt_o), 128'd0);
    check("rst_data",  128'(svc_data_o), 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Single targeted flit
    send(BR_SVC_TGT, ADDR[7:0], 32'hDEADBEEF, 1'b1);
    check("t1_rx",      128'(svc_rx_o),           128'd1);
    check("t1_count",   128'(count_o),            128'd1);
    check("t1_payload", 128'(svc_data_o.payload), 128'hDEADBEEF);
    pop_check();
    check("t1_rx_after_pop",    128'(svc_rx_o), 128'd0);
    check("t1_count_after_pop", 128'(count_o),  128'd0);

    // Burst of DEPTH+2 flits with no pops
    for (int i = 0; i < DEPTH; i++) send(BR_SVC_ALL, 8'hEE, 32'(i), 1'b1);
    check("burst_count_full", 128'(count_o),  128'(DEPTH));
    check("burst_rx",         128'(svc_rx_o), 128'd1);
    drive_flit(BR_SVC_ALL, 8'hEE, 32'(DEPTH));
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (br_ack_o) acks++;
    end
    check("burst_held_while_full", 128'(acks), 128'd0);
    pop_check();
    check("burst_no_ack_at_pop", 128'(br_ack_o), 128'd0);
    tick();
    check("burst_ack_after_pop", 128'(br_ack_o), 128'd1);
    if (br_ack_o) exp_q.push_back(model_entry(cur_flit));
    br_req_i = 1'b0;
    tick();
    check("burst_refill_count", 128'(count_o), 128'(DEPTH));
    drive_flit(BR_SVC_ALL, 8'hEE, 32'(DEPTH + 1));
    tick();
    tick();
    check("burst_tenth_held", 128'(br_ack_o), 128'd0);
    iter = 0;
    while ((exp_q.size() > 0 || br_req_i) && iter < 40) begin
      if (svc_rx_o) pop_check();
      else tick();
      check("burst_count_bound", 128'(count_o <= CW'(DEPTH)), 128'd1);
      if (br_req_i && br_ack_o) begin
        exp_q.push_back(model_entry(cur_flit));
        br_req_i = 1'b0;
      end
      iter++;
    end
    check("burst_drained_count", 128'(count_o),  128'd0);
    check("burst_drained_rx",    128'(svc_rx_o), 128'd0);

    // Filter table
    for (int v = 0; v < 6; v++) begin
      send(vecs[v].svc, vecs[v].target, vecs[v].payload, vecs[v].accept);
      check($sformatf("vec%0d_count", v), 128'(count_o),    128'(vecs[v].exp_count));
      check($sformatf("vec%0d_drop", v),  128'(drop_cnt_o), 128'(vecs[v].exp_drop));
    end
    pop_check();
    pop_check();
    check("filter_drained", 128'(count_o), 128'd0);

    // Clear coincident with a discard
    drive_flit(BR_SVC_TGT, ADDR[7:0] + 8'd2, 32'h200);
    drop_clr_i = 1'b1;
    tick();
    drop_clr_i = 1'b0;
    br_req_i   = 1'b0;
    check("clr_vs_discard_ack",  128'(br_ack_o),   128'd1);
    check("clr_vs_discard_drop", 128'(drop_cnt_o), 128'd0);
    tick();
    check("clr_hold_drop",  128'(drop_cnt_o), 128'd0);
    check("clr_hold_count", 128'(count_o),    128'd0);

    // Wrap-around with overlapping push/pop
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive_flit(BR_SVC_ALL, 8'h01, 32'h1000 + 32'(i));
      wait_ack(lat);
      exp_q.push_back(model_entry(cur_flit));
      br_req_i = 1'b0;
      if (svc_rx_o) pop_check();
      else tick();
      check("wrap_count", 128'(count_o), 128'd1);
    end
    pop_check();
    check("wrap_empty", 128'(count_o), 128'd0);

    // NI acks while empty
    svc_ack_i = 1'b1;
    repeat (3) tick();
    svc_ack_i = 1'b0;
    check("empty_ack_count", 128'(count_o),  128'd0);
    check("empty_ack_rx",    128'(svc_rx_o), 128'd0);
    send(BR_SVC_ALL, 8'h02, 32'hCAFE0001, 1'b1);
    check("empty_ack_push_count", 128'(count_o), 128'd1);
    pop_check();
    check("empty_ack_pop_count", 128'(count_o), 128'd0);

    // Async reset mid-operation
    for (int i = 0; i < 5; i++) send(BR_SVC_ALL, 8'h03, 32'h500 + 32'(i), 1'b1);
    check("pre_reset_count", 128'(count_o), 128'd5);
    drive_flit(BR_SVC_ALL, 8'h03, 32'h600);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_ack",   128'(br_ack_o),   128'd0);
    check("async_rst_rx",    128'(svc_rx_o),   128'd0);
    check("async_rst_count", 128'(count_o),    128'd0);
    check("async_rst_data",  128'(svc_data_o), 128'd0);
    check("async_rst_drop",  128'(drop_cnt_o), 128'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wait_ack(lat);
    check("post_rst_ack", 128'(br_ack_o), 128'd1);
    exp_q.push_back(model_entry(cur_flit));
    br_req_i = 1'b0;
    tick();
    check("post_rst_count", 128'(count_o), 128'd1);
    pop_check();
    check("post_rst_empty", 128'(count_o), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
